mem: RTL and testbench

Memory-access stage between `ex` and the register file. It captures the combinational `ex` result, runs one word-wide access on the data bus with a req/ack handshake, and stalls upstream while the access is outstanding. It then issues a single-cycle register-file write with the ALU result, jump link value or load data.

---
 rtl/mem.sv | 142 ++++++++++++++
 tb/tb_mem.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem.sv
// -----------------------------------------------------------------------------
// mem : memory-access stage between ex and the register file.
//
// Captures the ex result on accept (valid_i && ready_o). Non-memory
// instructions are written back on the next cycle without leaving IDLE.
// Memory instructions move to BUSY, drive one word access on the data bus
// and hold every bus output stable until bus_ack_i. Loads write the
// acknowledged read data back on the cycle after the ack.
//
// Optional feature macro: MEM_MISALIGN_CHECK_EN
//   defined   : a misaligned memory access is rejected with a one-cycle
//               err_o pulse, with no bus request and no writeback.
//   undefined : err_o is absent and the address is silently aligned.
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   valid_i / ready_o            upstream handshake (ready only in IDLE)
//   mem_ena_i, mem_rw_i          memory access enable, direction (1 = write)
//   mem_addr_i, mem_data_i       byte address, store data
//   gprs_waddr_i, gprs_wdata_i   destination register, ALU/link result
//   bus_req_o, bus_we_o          data bus request, write enable
//   bus_addr_o, bus_wdata_o      word-aligned address, store data
//   bus_rdata_i, bus_ack_i       load data, access complete
//   gprs_we_o/waddr_o/wdata_o    register-file write port (one-cycle strobe)
//   err_o                        misaligned-access pulse (macro only)
// -----------------------------------------------------------------------------
module mem #(
  parameter int ADDR_ALIGN_BITS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        mem_ena_i,
  input  logic        mem_rw_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [4:0]  gprs_waddr_i,
  input  logic [31:0] gprs_wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        gprs_we_o,
  output logic [4:0]  gprs_waddr_o,
  output logic [31:0] gprs_wdata_o
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic        err_o
`endif
);

  localparam logic       MEM_READ   = 1'b0;
  localparam logic       MEM_WRITE  = 1'b1;
  localparam logic [4:0] REG_X0     = 5'd0;
  localparam logic [31:0] ALIGN_MASK = (32'd1 << ADDR_ALIGN_BITS) - 32'd1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic        rw_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [4:0]  dest_reg;
  logic        accept;

  assign ready_o     = (state == IDLE);
  assign bus_req_o   = (state == BUSY);
  assign accept      = valid_i && ready_o;
  // Latched values only change on accept, so the bus side is stable for the
  // whole BUSY period.
  assign bus_we_o    = (rw_reg == MEM_WRITE);
  assign bus_addr_o  = addr_reg & ~ALIGN_MASK;
  assign bus_wdata_o = wdata_reg;

`ifdef MEM_MISALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |(mem_addr_i & ALIGN_MASK);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rw_reg       <= MEM_READ;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      dest_reg     <= REG_X0;
      gprs_we_o    <= 1'b0;
      gprs_waddr_o <= '0;
      gprs_wdata_o <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      err_o        <= 1'b0;
`endif
    end else begin
      // Strobes default low; they are single-cycle pulses.
      gprs_we_o <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      err_o     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            if (!mem_ena_i) begin
              // Writes to x0 are dropped entirely so the write port keeps
              // its previous address/data while the strobe is low.
              if (gprs_waddr_i != REG_X0) begin
                gprs_we_o    <= 1'b1;
                gprs_waddr_o <= gprs_waddr_i;
                gprs_wdata_o <= gprs_wdata_i;
              end
            end
`ifdef MEM_MISALIGN_CHECK_EN
            else if (misaligned) begin
              err_o <= 1'b1;
            end
`endif
            else begin
              rw_reg    <= mem_rw_i;
              addr_reg  <= mem_addr_i;
              wdata_reg <= mem_data_i;
              dest_reg  <= gprs_waddr_i;
              state     <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus_ack_i) begin
            state <= IDLE;
            if (rw_reg == MEM_READ && dest_reg != REG_X0) begin
              gprs_we_o    <= 1'b1;
              gprs_waddr_o <= dest_reg;
              gprs_wdata_o <= bus_rdata_i;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem.sv
// -----------------------------------------------------------------------------
// tb_mem : self-checking bench for the mem stage.
// Directed steps from the test plan followed by a randomized instruction
// stream. Expected values come from a transaction-level view: each
// instruction's writeback, bus address and handshake timing are derived
// arithmetically, and the register-file write port is expected to hold the
// last written address/data whenever the strobe is low.
// -----------------------------------------------------------------------------
module tb_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        mem_ena_i = 1'b0;
  logic        mem_rw_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_data_i = '0;
  logic [4:0]  gprs_waddr_i = '0;
  logic [31:0] gprs_wdata_i = '0;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_ack_i = 1'b0;
  logic        gprs_we_o;
  logic [4:0]  gprs_waddr_o;
  logic [31:0] gprs_wdata_o;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        err_o;
`endif

  int checks = 0;
  int errors = 0;

  // Model of the register-file write port's last written values.
  logic [4:0]  last_waddr_m = '0;
  logic [31:0] last_wdata_m = '0;

  mem #(.ADDR_ALIGN_BITS(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .mem_ena_i(mem_ena_i),
    .mem_rw_i(mem_rw_i),
    .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i),
    .gprs_waddr_i(gprs_waddr_i),
    .gprs_wdata_i(gprs_wdata_i),
    .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i),
    .gprs_we_o(gprs_we_o),
    .gprs_waddr_o(gprs_waddr_o),
    .gprs_wdata_o(gprs_wdata_o)
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    .err_o(err_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Checks the write port; a strobe updates the model, otherwise the
  // address/data must hold.
  task automatic check_wb(input string tag, input logic exp_we,
                          input logic [4:0] wa, input logic [31:0] wd);
    chk({tag, "_we"}, {31'd0, gprs_we_o}, {31'd0, exp_we});
    if (exp_we) begin
      last_waddr_m = wa;
      last_wdata_m = wd;
    end
    chk({tag, "_waddr"}, {27'd0, gprs_waddr_o}, {27'd0, last_waddr_m});
    chk({tag, "_wdata"}, gprs_wdata_o, last_wdata_m);
  endtask

  // One non-memory instruction; valid is left low on return so that
  // consecutive calls keep valid high with no bubble.
  task automatic alu(input logic [4:0] wa, input logic [31:0] wd);
    valid_i      = 1'b1;
    mem_ena_i    = 1'b0;
    mem_rw_i     = $urandom_range(0, 1);
    mem_addr_i   = $urandom;
    gprs_waddr_i = wa;
    gprs_wdata_i = wd;
    // A stray ack while idle must have no effect.
    bus_ack_i    = $urandom_range(0, 1);
    bus_rdata_i  = $urandom;
    step();
    valid_i   = 1'b0;
    bus_ack_i = 1'b0;
    chk("alu_ready", {31'd0, ready_o}, 32'd1);
    chk("alu_req", {31'd0, bus_req_o}, 32'd0);
    check_wb("alu", wa != 5'd0, wa, wd);
    $display("ALU   x%0d <= 0x%08h", wa, wd);
  endtask

  // One memory instruction acknowledged k cycles after the first BUSY cycle.
  task automatic memop(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] wa, input int k, input logic [31:0] rd);
    logic [31:0] exp_addr;
    exp_addr     = addr - (addr % 4);
    valid_i      = 1'b1;
    mem_ena_i    = 1'b1;
    mem_rw_i     = rw;
    mem_addr_i   = addr;
    mem_data_i   = data;
    gprs_waddr_i = wa;
    gprs_wdata_i = $urandom;
    step();
    valid_i   = 1'b0;
    mem_ena_i = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
    if ((addr % 4) != 0) begin
      chk("mis_err", {31'd0, err_o}, 32'd1);
      chk("mis_req", {31'd0, bus_req_o}, 32'd0);
      chk("mis_ready", {31'd0, ready_o}, 32'd1);
      check_wb("mis", 1'b0, wa, data);
      step();
      chk("mis_err_end", {31'd0, err_o}, 32'd0);
      chk("mis_req_end", {31'd0, bus_req_o}, 32'd0);
      $display("MISAL %s addr=0x%08h rejected", rw ? "ST" : "LD", addr);
      return;
    end
`endif
    for (int i = 0; i <= k; i++) begin
      chk("busy_req", {31'd0, bus_req_o}, 32'd1);
      chk("busy_ready", {31'd0, ready_o}, 32'd0);
      chk("busy_addr", bus_addr_o, exp_addr);
      chk("busy_we", {31'd0, bus_we_o}, {31'd0, rw});
      if (rw) chk("busy_wdata", bus_wdata_o, data);
      check_wb("busy", 1'b0, wa, rd);
`ifdef MEM_MISALIGN_CHECK_EN
      chk("busy_err", {31'd0, err_o}, 32'd0);
`endif
      if (i == k) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = rd;
      end
      step();
    end
    bus_ack_i   = 1'b0;
    bus_rdata_i = $urandom;
    chk("done_req", {31'd0, bus_req_o}, 32'd0);
    chk("done_ready", {31'd0, ready_o}, 32'd1);
    check_wb("done", (rw == 1'b0) && (wa != 5'd0), wa, rd);
    $display("%s    x%0d addr=0x%08h k=%0d data=0x%08h", rw ? "ST" : "LD", wa, addr, k,
             rw ? data : rd);
  endtask

  initial begin
    // Reset state.
    rst_n = 1'b0;
    step();
    step();
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_req", {31'd0, bus_req_o}, 32'd0);
    chk("rst_we", {31'd0, bus_we_o}, 32'd0);
    chk("rst_addr", bus_addr_o, 32'd0);
    chk("rst_bwdata", bus_wdata_o, 32'd0);
    check_wb("rst", 1'b0, 5'd0, 32'd0);
`ifdef MEM_MISALIGN_CHECK_EN
    chk("rst_err", {31'd0, err_o}, 32'd0);
`endif
    $display("RESET released");
    rst_n = 1'b1;
    step();

    // Directed steps.
    alu(5'd5, 32'h0000_1234);
    memop(1'b0, 32'h0000_0100, 32'h0, 5'd3, 3, 32'hDEAD_BEEF);
    memop(1'b1, 32'h0000_0204, 32'h0000_CAFE, 5'd0, 0, 32'h0);
    memop(1'b0, 32'h0000_0040, 32'h0, 5'd0, 1, 32'h1357_9BDF);
    alu(5'd0, 32'hFFFF_0000);
    // Back-to-back ALU instructions: one writeback per cycle.
    alu(5'd1, 32'h1111_1111);
    alu(5'd2, 32'h2222_2222);
    alu(5'd31, 32'h3333_3333);
    memop(1'b0, 32'h0000_0103, 32'h0, 5'd4, 1, 32'hA5A5_5A5A);

    // Valid held during BUSY is not consumed; it is accepted in the same
    // cycle as the load writeback.
    valid_i      = 1'b1;
    mem_ena_i    = 1'b1;
    mem_rw_i     = 1'b0;
    mem_addr_i   = 32'h0000_0080;
    gprs_waddr_i = 5'd9;
    step();
    mem_ena_i    = 1'b0;
    gprs_waddr_i = 5'd7;
    gprs_wdata_i = 32'h0000_0055;
    chk("hold_ready", {31'd0, ready_o}, 32'd0);
    chk("hold_req", {31'd0, bus_req_o}, 32'd1);
    check_wb("hold_b1", 1'b0, 5'd0, 32'd0);
    step();
    chk("hold_req2", {31'd0, bus_req_o}, 32'd1);
    check_wb("hold_b2", 1'b0, 5'd0, 32'd0);
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'h1111_2222;
    step();
    bus_ack_i = 1'b0;
    chk("hold_done_ready", {31'd0, ready_o}, 32'd1);
    chk("hold_done_req", {31'd0, bus_req_o}, 32'd0);
    check_wb("hold_ld", 1'b1, 5'd9, 32'h1111_2222);
    step();
    valid_i = 1'b0;
    check_wb("hold_alu", 1'b1, 5'd7, 32'h0000_0055);
    chk("hold_alu_req", {31'd0, bus_req_o}, 32'd0);
    $display("HOLD  LD x9 then ALU x7 accepted with load writeback");

    // Reset in the second BUSY cycle with a simultaneous ack.
    valid_i      = 1'b1;
    mem_ena_i    = 1'b1;
    mem_rw_i     = 1'b0;
    mem_addr_i   = 32'h0000_0300;
    gprs_waddr_i = 5'd3;
    step();
    valid_i   = 1'b0;
    mem_ena_i = 1'b0;
    chk("rb_req1", {31'd0, bus_req_o}, 32'd1);
    step();
    chk("rb_req2", {31'd0, bus_req_o}, 32'd1);
    rst_n       = 1'b0;
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'hBAD0_BAD0;
    step();
    rst_n     = 1'b1;
    bus_ack_i = 1'b0;
    last_waddr_m = '0;
    last_wdata_m = '0;
    chk("rb_req", {31'd0, bus_req_o}, 32'd0);
    chk("rb_ready", {31'd0, ready_o}, 32'd1);
    check_wb("rb", 1'b0, 5'd0, 32'd0);
    step();
    chk("rb_req_after", {31'd0, bus_req_o}, 32'd0);
    check_wb("rb_after", 1'b0, 5'd0, 32'd0);
    $display("RESET during BUSY, access abandoned");

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [4:0] wa;
      kind = $urandom_range(0, 2);
      wa   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      if (kind == 0)
        alu(wa, $urandom);
      else
        memop(kind == 2, $urandom & 32'h0000_FFFF, $urandom, wa,
              $urandom_range(0, 4), $urandom);
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
